mem_arbiter: RTL and testbench

//  Shares the processor's single external memory port (mem_read/mem_write/mem_addr/mem_wdata/mem_rdata)

---
 rtl/mem_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares the single external memory port between the instruction-fetch
//   requester (IF) and the data-access requester (MEM stage). Each granted
//   access drives the memory strobes for MEM_LATENCY cycles. The returned word
//   is then captured, and the owner sees a one-cycle ack. The data side wins
//   contention. A starvation counter forces a fetch grant after STARVE_LIMIT
//   consecutive data grants that were made while a fetch was waiting.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   if_req/if_addr    fetch request (held until if_ack) and its address
//   if_ack/if_rdata   one-cycle completion pulse and registered fetched word
//   if_stall          fetch pending and not acknowledged this cycle
//   d_read/d_write    data request (held until d_ack); both set means write
//   d_addr/d_wdata    data address and write data
//   d_ack/d_rdata     one-cycle completion pulse and registered read word
//   d_stall           data request pending and not acknowledged this cycle
//   mem_read/write    external strobes (registered, never both high)
//   mem_addr/wdata    external address/write data (registered, held)
//   mem_rdata         external read data, sampled in the last access cycle
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int WORD_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [WORD_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [WORD_WIDTH-1:0] if_rdata,
  output logic                  if_stall,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [WORD_WIDTH-1:0] d_addr,
  input  logic [WORD_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [WORD_WIDTH-1:0] d_rdata,
  output logic                  d_stall,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [WORD_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [STV_W-1:0]      starve_q, starve_d;
  logic                  owner_is_d_q, owner_is_d_d;
  logic                  if_ack_q, if_ack_d;
  logic                  d_ack_q, d_ack_d;
  logic [WORD_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [WORD_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [WORD_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic d_req;
  logic grant_if;

  assign d_req = d_read | d_write;

  // Fetch wins only when it is alone or has been passed over STARVE_LIMIT times.
  assign grant_if = if_req & (~d_req | (starve_q == STV_MAX));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_is_d_d = owner_is_d_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (if_req | d_req) begin
          state_d = ACCESS;
          cnt_d   = CNT_LOAD;
          if (grant_if) begin
            owner_is_d_d = 1'b0;
            mem_addr_d   = if_addr;
            mem_read_d   = 1'b1;
            mem_write_d  = 1'b0;
          end else begin
            // A simultaneous read+write request is carried out as a write.
            owner_is_d_d = 1'b1;
            mem_addr_d   = d_addr;
            mem_read_d   = ~d_write;
            mem_write_d  = d_write;
            if (d_write) begin
              mem_wdata_d = d_wdata;
            end
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d     = RESP;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (owner_is_d_q) begin
            d_ack_d = 1'b1;
            if (mem_read_q) begin
              d_rdata_d = mem_rdata;
            end
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // Counts data grants made while a fetch waits; any idle fetch clears it.
  always_comb begin
    starve_d = starve_q;
    if (!if_req) begin
      starve_d = '0;
    end else if ((state_q == IDLE) && (if_req | d_req)) begin
      if (grant_if) begin
        starve_d = '0;
      end else if (starve_q != STV_MAX) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      starve_q     <= '0;
      owner_is_d_q <= 1'b0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      starve_q     <= starve_d;
      owner_is_d_q <= owner_is_d_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_stall  = if_req & ~if_ack_q;
  assign d_stall   = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int W = 32;
  localparam int L = 2;
  localparam int SL = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         if_req = 1'b0;
  logic [W-1:0] if_addr = '0;
  logic         if_ack;
  logic [W-1:0] if_rdata;
  logic         if_stall;
  logic         d_read = 1'b0;
  logic         d_write = 1'b0;
  logic [W-1:0] d_addr = '0;
  logic [W-1:0] d_wdata = '0;
  logic         d_ack;
  logic [W-1:0] d_rdata;
  logic         d_stall;
  logic         mem_read;
  logic         mem_write;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .WORD_WIDTH  (W),
    .MEM_LATENCY (L),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_rdata (if_rdata),
    .if_stall (if_stall),
    .d_read   (d_read),
    .d_write  (d_write),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .d_stall  (d_stall),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         if_req;
    logic         d_read;
    logic         d_write;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic [W-1:0] mem_val;
    logic         exp_rd;
    logic         exp_wr;
    logic [W-1:0] exp_if_rdata;
    logic [W-1:0] exp_d_rdata;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Exclusivity of strobes and acks, checked every cycle out of reset.
  always @(negedge clk) begin
    if (rst) begin
      check("mem_strobe_excl", {31'd0, mem_read & mem_write}, 32'd0);
      check("ack_excl", {31'd0, if_ack & d_ack}, 32'd0);
    end
  end

  task automatic run_vec(input int idx, input vec_t v);
    if_req    = v.if_req;
    if_addr   = v.addr;
    d_read    = v.d_read;
    d_write   = v.d_write;
    d_addr    = v.addr;
    d_wdata   = v.wdata;
    mem_rdata = 32'hBAD0_0000;
    #1;
    check($sformatf("v%0d if_stall_req", idx), {31'd0, if_stall}, {31'd0, v.if_req});
    check($sformatf("v%0d d_stall_req", idx), {31'd0, d_stall}, {31'd0, v.d_read | v.d_write});
    for (int i = 0; i < L; i++) begin
      tick();
      mem_rdata = (i == L - 1) ? v.mem_val : (32'hBAD0_0000 | i);
      check($sformatf("v%0d mem_read c%0d", idx, i), {31'd0, mem_read}, {31'd0, v.exp_rd});
      check($sformatf("v%0d mem_write c%0d", idx, i), {31'd0, mem_write}, {31'd0, v.exp_wr});
      check($sformatf("v%0d mem_addr c%0d", idx, i), mem_addr, v.addr);
      if (v.exp_wr) check($sformatf("v%0d mem_wdata c%0d", idx, i), mem_wdata, v.wdata);
      check($sformatf("v%0d no_ack c%0d", idx, i), {30'd0, if_ack, d_ack}, 32'd0);
    end
    tick();
    mem_rdata = 32'hBAD1_1111;
    check($sformatf("v%0d if_ack", idx), {31'd0, if_ack}, {31'd0, v.if_req});
    check($sformatf("v%0d d_ack", idx), {31'd0, d_ack}, {31'd0, ~v.if_req});
    check($sformatf("v%0d if_rdata", idx), if_rdata, v.exp_if_rdata);
    check($sformatf("v%0d d_rdata", idx), d_rdata, v.exp_d_rdata);
    check($sformatf("v%0d strobes_resp", idx), {30'd0, mem_read, mem_write}, 32'd0);
    check($sformatf("v%0d stalls_resp", idx), {30'd0, if_stall, d_stall}, 32'd0);
    if_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
    tick();
    check($sformatf("v%0d acks_after", idx), {30'd0, if_ack, d_ack}, 32'd0);
    check($sformatf("v%0d addr_hold", idx), mem_addr, v.addr);
  endtask

  initial begin
    int  seq [8];
    int  n;
    logic [W-1:0] exp_seq [7];

    //            if  rd  wr  addr          wdata         mem_val       rd  wr  if_rdata      d_rdata
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0,        32'hDEAD_BEEF, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678, 32'hFFFF_0000, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0,        32'hCAFE_F00D, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h0000_0300, 32'hA5A5_A5A5, 32'h1111_1111, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'h55AA_55AA, 32'h2222_2222, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h0,        32'h1357_2468, 1'b1, 1'b0, 32'h1357_2468, 32'hCAFE_F00D};

    // Reset state
    rst = 1'b0;
    tick();
    tick();
    check("rst acks", {30'd0, if_ack, d_ack}, 32'd0);
    check("rst strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    check("rst if_rdata", if_rdata, 32'd0);
    check("rst d_rdata", d_rdata, 32'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Data request dropped and inputs changed mid-access
    d_read = 1'b1; d_addr = 32'h0000_0500; mem_rdata = 32'h0BAD_F00D;
    tick();
    d_read = 1'b0; d_addr = 32'h0000_0600;
    #1;
    check("drop d_stall", {31'd0, d_stall}, 32'd0);
    tick();
    check("drop addr held", mem_addr, 32'h0000_0500);
    check("drop mem_read held", {31'd0, mem_read}, 32'd1);
    tick();
    check("drop d_ack", {31'd0, d_ack}, 32'd1);
    check("drop d_rdata", d_rdata, 32'h0BAD_F00D);
    tick();
    check("drop ack single", {31'd0, d_ack}, 32'd0);
    tick();
    check("drop stays idle", {30'd0, mem_read, mem_write}, 32'd0);

    // Contention: data served first, then fetch
    if_req = 1'b1; if_addr = 32'h0000_0080;
    d_read = 1'b1; d_addr = 32'h0000_0180; mem_rdata = 32'h0000_0077;
    tick();
    check("cont first addr", mem_addr, 32'h0000_0180);
    tick();
    tick();
    check("cont d_ack", {30'd0, if_ack, d_ack}, 32'd1);
    check("cont d_rdata", d_rdata, 32'h0000_0077);
    d_read = 1'b0; mem_rdata = 32'h0000_0088;
    tick();
    tick();
    check("cont second addr", mem_addr, 32'h0000_0080);
    check("cont second rd", {31'd0, mem_read}, 32'd1);
    tick();
    tick();
    check("cont if_ack", {30'd0, if_ack, d_ack}, 32'd2);
    check("cont if_rdata", if_rdata, 32'h0000_0088);
    if_req = 1'b0;
    tick();

    // Starvation: 4 data grants, then the fetch, then data resumes
    if_req = 1'b1; if_addr = 32'h0000_0090;
    d_read = 1'b1; d_addr = 32'h0000_0190; mem_rdata = 32'h0000_00AA;
    n = 0;
    for (int cyc = 0; cyc < 80 && n < 7; cyc++) begin
      tick();
      if (d_ack) begin seq[n] = 1; n++; end
      if (if_ack) begin seq[n] = 0; n++; if_req = 1'b0; end
    end
    check("starve ack count", n, 7);
    exp_seq = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd0, 32'd1, 32'd1};
    for (int i = 0; i < 7; i++) begin
      if (i < n) check($sformatf("starve ack%0d is_data", i), seq[i], exp_seq[i]);
    end
    d_read = 1'b0; if_req = 1'b0;
    tick();
    tick();

    // Reset asserted mid-access
    if_req = 1'b1; if_addr = 32'h0000_0060; mem_rdata = 32'h0000_0099;
    tick();
    check("mrst pre mem_read", {31'd0, mem_read}, 32'd1);
    rst = 1'b0;
    #1;
    check("mrst strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check("mrst acks", {30'd0, if_ack, d_ack}, 32'd0);
    check("mrst if_rdata", if_rdata, 32'd0);
    check("mrst d_rdata", d_rdata, 32'd0);
    check("mrst mem_addr", mem_addr, 32'd0);
    if_req = 1'b0;
    #2;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("mrst idle acks c%0d", i), {30'd0, if_ack, d_ack}, 32'd0);
      check($sformatf("mrst idle strobes c%0d", i), {30'd0, mem_read, mem_write}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
